// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command scheduler: state encoding, defaults,
// requester indices and the two-port round-robin pick.
package spi_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  // Requester indices
  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_ADC  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStartCmd,
    StWaitCmd,
    StStartRd,
    StWaitRd,
    StDone
  } state_e;

  // Lone requester wins; on contention the port not granted last time wins.
  function automatic logic pick_winner(input logic [1:0] req, input logic last);
    if (req == 2'b01) return REQ_HOST;
    if (req == 2'b10) return REQ_ADC;
    return ~last;
  endfunction

endpackage

// File: rtl/spi_timeout_ctr.sv
// Per-transfer watchdog: counts waiting cycles and flags the final allowed cycle.
module spi_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CntW'(TIMEOUT_CYC - 1));

  // Next count: clear wins, then count up until the last allowed cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_cmd_sched.sv
// Two-port arbiter and sequencer for the shared SPI master: command transfer,
// optional read transfer, timeout guard, one-cycle acknowledge with read data.
module spi_cmd_sched
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        req_i,
  input  logic [1:0]        rd_i,
  input  logic [DATA_W-1:0] cmd0_i,
  input  logic [DATA_W-1:0] cmd1_i,
  output logic [1:0]        ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              spi_start_o,
  output logic [DATA_W-1:0] spi_tx_o,
  input  logic              spi_done_i,
  input  logic [DATA_W-1:0] spi_rx_i,
  output logic              spi_cmd_reading_o
);

  state_e            state_q;
  logic              last_q;
  logic              win_q;
  logic              rd_q;
  logic [1:0]        ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              busy_q;
  logic              start_q;
  logic [DATA_W-1:0] tx_q;
  logic              reading_q;

  logic winner;
  logic tmo_clear, tmo_enable, tmo_expired;

  assign winner     = pick_winner(req_i, last_q);
  // Clearing in the START states means each WAIT state is entered with count 0.
  assign tmo_clear  = (state_q == StStartCmd) || (state_q == StStartRd);
  assign tmo_enable = (state_q == StWaitCmd) || (state_q == StWaitRd);

  spi_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_enable),
    .expired_o (tmo_expired)
  );

  // Sequencer FSM; every output is set on the edge that enters its state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      rd_q      <= 1'b0;
      ack_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      tx_q      <= '0;
      reading_q <= 1'b0;
    end else begin
      ack_q   <= '0;
      start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req_i) begin
            win_q   <= winner;
            rd_q    <= rd_i[winner];
            tx_q    <= winner ? cmd1_i : cmd0_i;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StStartCmd;
          end
        end
        StStartCmd: state_q <= StWaitCmd;
        StWaitCmd: begin
          // A done arriving in the expiry cycle still counts as success.
          if (spi_done_i && rd_q) begin
            start_q   <= 1'b1;
            tx_q      <= '0;
            reading_q <= 1'b1;
            state_q   <= StStartRd;
          end else if (spi_done_i || tmo_expired) begin
            ack_q   <= 2'b01 << win_q;
            rdata_q <= '0;
            err_q   <= ~spi_done_i;
            state_q <= StDone;
          end
        end
        StStartRd: state_q <= StWaitRd;
        StWaitRd: begin
          if (spi_done_i || tmo_expired) begin
            ack_q     <= 2'b01 << win_q;
            rdata_q   <= spi_done_i ? spi_rx_i : '0;
            err_q     <= ~spi_done_i;
            reading_q <= 1'b0;
            state_q   <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          last_q  <= win_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack_o             = ack_q;
  assign rdata_o           = rdata_q;
  assign err_o             = err_q;
  assign busy_o            = busy_q;
  assign spi_start_o       = start_q;
  assign spi_tx_o          = tx_q;
  assign spi_cmd_reading_o = reading_q;

endmodule

// File: tb/tb_spi_cmd_sched.sv
// Self-checking bench for spi_cmd_sched: directed vector table, hand-written
// contention/reset sequences and randomized transactions against a rule model.
module tb_spi_cmd_sched;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  rd = '0;
  logic [15:0] cmd0 = '0;
  logic [15:0] cmd1 = '0;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rx = '0;
  logic [1:0]  ack;
  logic [15:0] rdata;
  logic        err;
  logic        busy;
  logic        spi_start;
  logic [15:0] spi_tx;
  logic        reading;

  int n_chk = 0;
  int n_pass = 0;
  logic last_m = 1'b1;

  spi_cmd_sched #(
    .DATA_W      (16),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_i             (req),
    .rd_i              (rd),
    .cmd0_i            (cmd0),
    .cmd1_i            (cmd1),
    .ack_o             (ack),
    .rdata_o           (rdata),
    .err_o             (err),
    .busy_o            (busy),
    .spi_start_o       (spi_start),
    .spi_tx_o          (spi_tx),
    .spi_done_i        (spi_done),
    .spi_rx_i          (spi_rx),
    .spi_cmd_reading_o (reading)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Plays the SPI master for one WAIT state; returns on the negedge after it.
  task automatic wait_phase(input string nm, input int d, input logic rdph,
                            input logic [15:0] rx, input logic [15:0] e_tx);
    for (int k = 0; k < T; k++) begin
      chk({nm, "/wait_ack"}, 32'(ack), 32'(0));
      chk({nm, "/wait_start"}, 32'(spi_start), 32'(0));
      chk({nm, "/wait_reading"}, 32'(reading), 32'(rdph));
      chk({nm, "/wait_tx"}, 32'(spi_tx), 32'(e_tx));
      chk({nm, "/wait_busy"}, 32'(busy), 32'(1));
      spi_done = (k == d);
      spi_rx   = (k == d) ? rx : 16'($urandom);
      @(negedge clk);
      if (k == d) break;
    end
    spi_done = 1'b0;
  endtask

  // One full transaction starting from an IDLE-cycle negedge, ending at the
  // IDLE-cycle negedge after DONE. d1/d2 >= T means no SPI_done (timeout).
  task automatic run_txn(input string nm, input logic [1:0] rq, input logic [1:0] r,
                         input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] rx,
                         input int d1, input int d2, input logic [1:0] e_ack,
                         input logic [15:0] e_rdata, input logic e_err);
    logic w;
    logic [15:0] e_tx;
    w    = e_ack[1];
    e_tx = w ? c1 : c0;
    req = rq; rd = r; cmd0 = c0; cmd1 = c1;
    @(negedge clk);
    chk({nm, "/start"}, 32'(spi_start), 32'(1));
    chk({nm, "/start_tx"}, 32'(spi_tx), 32'(e_tx));
    chk({nm, "/start_busy"}, 32'(busy), 32'(1));
    chk({nm, "/start_reading"}, 32'(reading), 32'(0));
    // Late changes to cmd/rd and a stray done in START must all be ignored.
    rd = ~r; cmd0 = ~c0; cmd1 = ~c1;
    spi_done = 1'($urandom_range(0, 1));
    spi_rx = 16'($urandom);
    @(negedge clk);
    wait_phase(nm, d1, 1'b0, 16'($urandom), e_tx);
    if (r[w] && d1 < T) begin
      chk({nm, "/rd_start"}, 32'(spi_start), 32'(1));
      chk({nm, "/rd_tx"}, 32'(spi_tx), 32'(0));
      chk({nm, "/rd_reading"}, 32'(reading), 32'(1));
      spi_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      wait_phase(nm, d2, 1'b1, rx, 16'h0000);
    end
    chk({nm, "/ack"}, 32'(ack), 32'(e_ack));
    chk({nm, "/rdata"}, 32'(rdata), 32'(e_rdata));
    chk({nm, "/err"}, 32'(err), 32'(e_err));
    chk({nm, "/done_start"}, 32'(spi_start), 32'(0));
    chk({nm, "/done_reading"}, 32'(reading), 32'(0));
    chk({nm, "/done_busy"}, 32'(busy), 32'(1));
    @(negedge clk);
    chk({nm, "/idle_ack"}, 32'(ack), 32'(0));
    chk({nm, "/idle_busy"}, 32'(busy), 32'(0));
    last_m = w;
  endtask

  typedef struct {
    logic [1:0]  rq;
    logic [1:0]  rd;
    logic [15:0] c0;
    logic [15:0] c1;
    logic [15:0] rx;
    int          d1;
    int          d2;
    logic [1:0]  ack;
    logic [15:0] rdata;
    logic        err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [1:0]  rq, r;
    logic [15:0] c0, c1, rx, e_rdata;
    logic        w, timed;
    int          d1, d2;

    // Directed vectors; the model pointer starts at 1 after the contention run.
    tbl[0] = '{2'b01, 2'b00, 16'hA5A5, 16'h0000, 16'h0000, 8, 0, 2'b01, 16'h0000, 1'b0};
    tbl[1] = '{2'b10, 2'b10, 16'h0000, 16'h8012, 16'h3C3C, 3, 5, 2'b10, 16'h3C3C, 1'b0};
    tbl[2] = '{2'b01, 2'b00, 16'h1234, 16'h0000, 16'h0000, 99, 0, 2'b01, 16'h0000, 1'b1};
    tbl[3] = '{2'b10, 2'b00, 16'h0000, 16'h5555, 16'h0000, 15, 0, 2'b10, 16'h0000, 1'b0};
    tbl[4] = '{2'b01, 2'b01, 16'h8001, 16'h0000, 16'hBEEF, 0, 15, 2'b01, 16'hBEEF, 1'b0};
    tbl[5] = '{2'b10, 2'b10, 16'h0000, 16'h8002, 16'h1111, 2, 99, 2'b10, 16'h0000, 1'b1};
    tbl[6] = '{2'b11, 2'b11, 16'h8033, 16'h8044, 16'hABCD, 4, 2, 2'b01, 16'hABCD, 1'b0};
    tbl[7] = '{2'b11, 2'b01, 16'h8066, 16'h0055, 16'h9999, 0, 0, 2'b10, 16'h0000, 1'b0};

    // Reset values
    @(negedge clk);
    chk("rst/ack", 32'(ack), 32'(0));
    chk("rst/rdata", 32'(rdata), 32'(0));
    chk("rst/err", 32'(err), 32'(0));
    chk("rst/busy", 32'(busy), 32'(0));
    chk("rst/start", 32'(spi_start), 32'(0));
    chk("rst/tx", 32'(spi_tx), 32'(0));
    chk("rst/reading", 32'(reading), 32'(0));
    rst = 1'b0;

    // Contention held from reset: 0,1,0,1
    run_txn("cont0", 2'b11, 2'b00, 16'h0A00, 16'h0B00, 16'h0, 1, 0, 2'b01, 16'h0, 1'b0);
    run_txn("cont1", 2'b11, 2'b00, 16'h0A01, 16'h0B01, 16'h0, 2, 0, 2'b10, 16'h0, 1'b0);
    run_txn("cont2", 2'b11, 2'b00, 16'h0A02, 16'h0B02, 16'h0, 0, 0, 2'b01, 16'h0, 1'b0);
    run_txn("cont3", 2'b11, 2'b00, 16'h0A03, 16'h0B03, 16'h0, 3, 0, 2'b10, 16'h0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].rq, tbl[i].rd, tbl[i].c0, tbl[i].c1, tbl[i].rx,
              tbl[i].d1, tbl[i].d2, tbl[i].ack, tbl[i].rdata, tbl[i].err);
    end

    // Reset in WAIT_RD: port 0 read leaves last=0 and nonzero rdata first.
    run_txn("pre_rst", 2'b01, 2'b01, 16'h8100, 16'h0, 16'h7777, 1, 1, 2'b01, 16'h7777, 1'b0);
    req = 2'b10; rd = 2'b10; cmd1 = 16'h8200;
    @(negedge clk);                 // START_CMD
    @(negedge clk); spi_done = 1'b1; // WAIT_CMD
    @(negedge clk); spi_done = 1'b0; // START_RD
    @(negedge clk);                 // WAIT_RD
    @(negedge clk);
    chk("mid/reading", 32'(reading), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst/ack", 32'(ack), 32'(0));
    chk("arst/rdata", 32'(rdata), 32'(0));
    chk("arst/err", 32'(err), 32'(0));
    chk("arst/busy", 32'(busy), 32'(0));
    chk("arst/start", 32'(spi_start), 32'(0));
    chk("arst/tx", 32'(spi_tx), 32'(0));
    chk("arst/reading", 32'(reading), 32'(0));
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    last_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      spi_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("post_rst/ack", 32'(ack), 32'(0));
      chk("post_rst/busy", 32'(busy), 32'(0));
    end
    spi_done = 1'b0;
    run_txn("post_rst", 2'b11, 2'b00, 16'hC0C0, 16'hC1C1, 16'h0, 2, 0, 2'b01, 16'h0, 1'b0);

    // Randomized transactions against the rule model
    for (int i = 0; i < 40; i++) begin
      rq = 2'($urandom_range(1, 3));
      r  = 2'($urandom);
      c0 = 16'($urandom);
      c1 = 16'($urandom);
      rx = 16'($urandom);
      d1 = ($urandom_range(0, 3) == 0) ? T + int'($urandom_range(0, 3)) : int'($urandom_range(0, T - 1));
      d2 = ($urandom_range(0, 3) == 0) ? T + int'($urandom_range(0, 3)) : int'($urandom_range(0, T - 1));
      w  = (rq == 2'b01) ? 1'b0 : (rq == 2'b10) ? 1'b1 : ~last_m;
      timed   = (d1 >= T) || (r[w] && d2 >= T);
      e_rdata = (timed || !r[w]) ? 16'h0000 : rx;
      run_txn($sformatf("rnd%0d", i), rq, r, c0, c1, rx, d1, d2, 2'b01 << w, e_rdata, timed);
      if ($urandom_range(0, 3) == 0) begin
        req = 2'b00;
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          spi_done = 1'($urandom_range(0, 1));
          @(negedge clk);
          chk("gap/busy", 32'(busy), 32'(0));
          chk("gap/ack", 32'(ack), 32'(0));
        end
        spi_done = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
